// File: rtl/hw6_seq_alu_if.sv
// Operand/result bus between the operand register file and the sequential ALU.
// The master drives the operation request. The slave returns ready, the result and the flags.
interface hw6_seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] aluin1;
    logic [WIDTH-1:0] aluin2;
    logic [2:0]       alu_control;
    logic             out_valid;
    logic [WIDTH-1:0] aluout;
    logic             alu_carry;
    logic             alu_zero;

    modport master (
        output in_valid, aluin1, aluin2, alu_control,
        input  in_ready, out_valid, aluout, alu_carry, alu_zero
    );

    modport slave (
        input  in_valid, aluin1, aluin2, alu_control,
        output in_ready, out_valid, aluout, alu_carry, alu_zero
    );
endinterface

// File: rtl/hw6_seq_alu.sv
// Registered WIDTH-bit ALU: single-cycle add/sub/logic/shift plus an iterative shift-add multiply.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; single-cycle ops complete at their accept edge
// MUL   | shift-add multiply in flight; inputs ignored until it completes
module hw6_seq_alu #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    hw6_seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   out_q;
    logic               carry_q;
    logic               zero_q;
    logic               valid_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcnd;
    logic [WIDTH-1:0]   mplr;
    logic [SHW-1:0]     cnt;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH:0]     srl_w;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;
    logic [2*WIDTH-1:0] acc_nxt;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.aluout    = out_q;
    assign bus.alu_carry = carry_q;
    assign bus.alu_zero  = zero_q;

    // Single-cycle datapath; SRL shifts a guard bit in below A so the last bit out lands in bit 0.
    always_comb begin
        sum_w    = {1'b0, bus.aluin1} + {1'b0, bus.aluin2};
        diff_w   = {1'b0, bus.aluin1} - {1'b0, bus.aluin2};
        srl_w    = {bus.aluin1, 1'b0} >> bus.aluin2[SHW-1:0];
        op_res   = '0;
        op_carry = 1'b0;
        case (bus.alu_control)
            OP_ADD: begin op_res = sum_w[WIDTH-1:0];  op_carry = sum_w[WIDTH];  end
            OP_SUB: begin op_res = diff_w[WIDTH-1:0]; op_carry = diff_w[WIDTH]; end
            OP_AND: op_res = bus.aluin1 & bus.aluin2;
            OP_OR:  op_res = bus.aluin1 | bus.aluin2;
            OP_XOR: op_res = bus.aluin1 ^ bus.aluin2;
            OP_SRL: begin op_res = srl_w[WIDTH:1];    op_carry = srl_w[0];      end
            default: begin op_res = '0; op_carry = 1'b0; end
        endcase
    end

    // Partial-product step of the multiply.
    always_comb begin
        acc_nxt = acc + (mplr[0] ? mcnd : '0);
    end

    // Control FSM with registered result, flags and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            acc     <= '0;
            mcnd    <= '0;
            mplr    <= '0;
            cnt     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.alu_control == OP_MUL) begin
                            mcnd  <= {{WIDTH{1'b0}}, bus.aluin1};
                            mplr  <= bus.aluin2;
                            acc   <= '0;
                            cnt   <= SHW'(WIDTH - 1);
                            state <= MUL;
                        end else begin
                            out_q   <= op_res;
                            carry_q <= op_carry;
                            zero_q  <= (op_res == '0);
                            valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    mcnd <= mcnd << 1;
                    mplr <= mplr >> 1;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == '0) begin
                        out_q   <= acc_nxt[WIDTH-1:0];
                        carry_q <= |acc_nxt[2*WIDTH-1:WIDTH];
                        zero_q  <= (acc_nxt[WIDTH-1:0] == '0);
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hw6_seq_alu.sv
// Bench for hw6_seq_alu: directed cases plus random ops on 16-bit and 8-bit instances,
// checked against an arithmetic reference model.
module tb_hw6_seq_alu;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    hw6_seq_alu_if #(.WIDTH(16)) bus16 ();
    hw6_seq_alu_if #(.WIDTH(8))  bus8 ();

    hw6_seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    hw6_seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {carry, result} computed with plain integer arithmetic.
    function automatic logic [32:0] model(input int w, input logic [2:0] op,
                                          input longint unsigned a, input longint unsigned b);
        longint unsigned mask;
        longint unsigned r;
        longint unsigned p;
        logic            c;
        int              sh;
        mask = (64'd1 << w) - 64'd1;
        a    = a & mask;
        b    = b & mask;
        c    = 1'b0;
        r    = 0;
        case (op)
            3'd0: begin r = a + b; c = (r > mask); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                sh = int'(b % longint'(w));
                r  = a >> sh;
                if (sh != 0) c = ((a >> (sh - 1)) & 64'd1) != 0;
            end
            3'd6: begin p = a * b; r = p; c = ((p >> w) != 0); end
            default: r = 0;
        endcase
        r = r & mask;
        return {c, 32'(r)};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic vld, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.in_valid = vld; bus8.alu_control = op;
            bus8.aluin1 = a[7:0]; bus8.aluin2 = b[7:0];
        end else begin
            bus16.in_valid = vld; bus16.alu_control = op;
            bus16.aluin1 = a[15:0]; bus16.aluin2 = b[15:0];
        end
    endtask

    task automatic sample(input bit w8, output logic ov, output logic ir, output logic [31:0] res,
                          output logic cy, output logic z);
        if (w8) begin
            ov = bus8.out_valid; ir = bus8.in_ready; res = 32'(bus8.aluout);
            cy = bus8.alu_carry; z = bus8.alu_zero;
        end else begin
            ov = bus16.out_valid; ir = bus16.in_ready; res = 32'(bus16.aluout);
            cy = bus16.alu_carry; z = bus16.alu_zero;
        end
    endtask

    task automatic check_result(input string tag, input bit w8, input logic [32:0] exp);
        logic ov, ir, cy, z;
        logic [31:0] res;
        sample(w8, ov, ir, res, cy, z);
        chk({tag, "_valid"}, 33'(ov), 33'd1);
        chk({tag, "_out"},   33'(res), 33'(exp[31:0]));
        chk({tag, "_carry"}, 33'(cy), 33'(exp[32]));
        chk({tag, "_zero"},  33'(z), 33'(exp[31:0] == 32'd0));
        chk({tag, "_ready"}, 33'(ir), 33'd1);
    endtask

    // Issue one op, wait for its result with a bounded cycle budget, then check the pulse drops and outputs hold.
    task automatic run_op(input string tag, input bit w8, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int          w;
        int          lat;
        logic [32:0] exp;
        logic        ov, ir, cy, z;
        logic [31:0] res;
        w   = w8 ? 8 : 16;
        exp = model(w, op, 64'(a), 64'(b));
        @(negedge clk);
        sample(w8, ov, ir, res, cy, z);
        chk({tag, "_ready_pre"}, 33'(ir), 33'd1);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, op, a, b);
        lat = 0;
        sample(w8, ov, ir, res, cy, z);
        if (op == 3'b110) begin
            chk({tag, "_busy"}, 33'(ir), 33'd0);
            while (!ov && lat < 100) begin
                @(posedge clk); #1;
                lat++;
                sample(w8, ov, ir, res, cy, z);
            end
            chk({tag, "_latency"}, 33'(lat), 33'(w));
        end
        check_result(tag, w8, exp);
        @(posedge clk); #1;
        sample(w8, ov, ir, res, cy, z);
        chk({tag, "_pulse"}, 33'(ov), 33'd0);
        chk({tag, "_hold"},  33'(res), 33'(exp[31:0]));
    endtask

    initial begin
        logic        ov, ir, cy, z;
        logic [31:0] res;
        logic [32:0] e_mul, e_add;
        int          lat;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

        // Reset state.
        #2;
        for (int k = 0; k < 2; k++) begin
            sample(k[0], ov, ir, res, cy, z);
            chk("rst_valid", 33'(ov), 33'd0);
            chk("rst_out",   33'(res), 33'd0);
            chk("rst_carry", 33'(cy), 33'd0);
            chk("rst_zero",  33'(z), 33'd0);
            chk("rst_ready", 33'(ir), 33'd1);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ADD then SUB.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 32'hffff, 32'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 32'h0a00, 32'h0a01);
        check_result("b2b_add", 1'b0, {1'b1, 32'h0000});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check_result("b2b_sub", 1'b0, {1'b1, 32'hffff});
        @(posedge clk); #1;
        sample(1'b0, ov, ir, res, cy, z);
        chk("b2b_pulse", 33'(ov), 33'd0);
        chk("b2b_hold",  33'(res), 33'h0ffff);

        // Directed single-cycle ops.
        run_op("sub_nb",   1'b0, 3'd1, 32'hffff, 32'hfff0);
        run_op("xor",      1'b0, 3'd4, 32'hf0f0, 32'habcd);
        run_op("srl1",     1'b0, 3'd5, 32'h8001, 32'h0001);
        run_op("srl0",     1'b0, 3'd5, 32'h8001, 32'h0000);
        run_op("srl15",    1'b0, 3'd5, 32'hc000, 32'h000f);
        run_op("and",      1'b0, 3'd2, 32'h0ff0, 32'h3c3c);
        run_op("or",       1'b0, 3'd3, 32'h0ff0, 32'h3c3c);
        run_op("rsvd",     1'b0, 3'd7, 32'h1234, 32'h5678);

        // Multiplies.
        run_op("mul_ff",   1'b0, 3'd6, 32'h00ff, 32'h0101);
        run_op("mul_ovf",  1'b0, 3'd6, 32'h1000, 32'h0010);
        run_op("mul_max",  1'b0, 3'd6, 32'hffff, 32'hffff);

        // ADD presented while a MUL is busy waits for in_ready, and must not disturb the MUL.
        e_mul = model(16, 3'd6, 64'h0123, 64'h0045);
        e_add = model(16, 3'd0, 64'h1111, 64'h2222);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd6, 32'h0123, 32'h0045);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 32'h1111, 32'h2222);
        lat = 0;
        sample(1'b0, ov, ir, res, cy, z);
        while (!ov && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            sample(1'b0, ov, ir, res, cy, z);
        end
        chk("mulq_latency", 33'(lat), 33'd16);
        check_result("mulq_mul", 1'b0, e_mul);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check_result("mulq_add", 1'b0, e_add);

        // Reset during a MUL aborts it.
        run_op("pre_rst", 1'b0, 3'd0, 32'h0005, 32'h0006);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd6, 32'h00ff, 32'h00ff);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        sample(1'b0, ov, ir, res, cy, z);
        chk("abort_out",   33'(res), 33'd0);
        chk("abort_carry", 33'(cy), 33'd0);
        chk("abort_zero",  33'(z), 33'd0);
        chk("abort_ready", 33'(ir), 33'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            sample(1'b0, ov, ir, res, cy, z);
            chk("abort_no_valid", 33'(ov), 33'd0);
        end
        run_op("post_rst_add", 1'b0, 3'd0, 32'd3, 32'd4);

        // 8-bit instance.
        run_op("w8_mul",   1'b1, 3'd6, 32'h0f, 32'h11);
        run_op("w8_add",   1'b1, 3'd0, 32'hff, 32'h01);
        run_op("w8_srl",   1'b1, 3'd5, 32'h81, 32'h07);

        // Random ops on both widths.
        for (int i = 0; i < 48; i++) begin
            run_op("rand", (i % 3) == 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
